// File: rtl/boot_mem_responder_if.sv
// Strobe/address/status bundle between the boot loader bus master and the memory responder.
// The tri-state Data bus stays a plain inout port on the responder.
interface boot_mem_responder_if #(
   parameter int DEPTH_LOG2 = 10
);
   logic [31:0]         Address;
   logic                CS;
   logic                WE;
   logic                OE;
   logic                Lock;
   logic                Ready;
   logic                Error;
   logic [DEPTH_LOG2:0] Words_Written;

   modport master (
      output Address, CS, WE, OE, Lock,
      input  Ready, Error, Words_Written
   );

   modport slave (
      input  Address, CS, WE, OE, Lock,
      output Ready, Error, Words_Written
   );
endinterface

// File: rtl/boot_mem_responder.sv
// Memory-side responder for the boot loader bus: wait states, word array, Ready/Error
// acknowledge, and a sticky write-protect over the low boot region.
module boot_mem_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_STATES = 2,
   parameter int ROM_WORDS   = 256
) (
   input  logic                  clock,
   input  logic                  reset_n,
   boot_mem_responder_if.slave   bus,
   inout  wire  [DATA_WIDTH-1:0] Data
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_ACCESS = 3'd2;
   localparam logic [2:0] S_ACK    = 3'd3;
   localparam logic [2:0] S_HOLD   = 3'd4;

   localparam int                  WORDS  = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] WW_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [2:0]            state;
   logic [3:0]            wcnt;
   logic [31:0]           addr_q;
   logic                  we_q;
   logic                  oe_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] rd_reg;
   logic                  err_q;
   logic                  lock_q;
   logic                  ready;
   logic                  error;
   logic [DEPTH_LOG2:0]   words_written;

   logic [DATA_WIDTH-1:0] mem [WORDS];

   logic [DEPTH_LOG2-1:0] idx;
   logic                  is_read;
   logic                  is_write;
   logic                  conflict;
   logic                  range_err;
   logic                  prot_err;
   logic                  req_err;
   logic                  commit;
   logic                  data_drive;

   always_comb begin
      idx        = addr_q[DEPTH_LOG2-1:0];
      is_read    = !oe_q && we_q;
      is_write   = !we_q && oe_q;
      conflict   = !we_q && !oe_q;
      range_err  = |addr_q[31:DEPTH_LOG2];
      prot_err   = is_write && lock_q && (addr_q < 32'(ROM_WORDS));
      req_err    = conflict || range_err || prot_err;
      commit     = (state == S_ACCESS) && !bus.CS && is_write && !req_err;
      // Read data is only driven while the master is still actively reading.
      data_drive = ((state == S_ACK) || (state == S_HOLD)) && is_read &&
                   !bus.CS && !bus.OE && bus.WE;
   end

   assign Data              = data_drive ? rd_reg : 'z;
   assign bus.Ready         = ready;
   assign bus.Error         = error;
   assign bus.Words_Written = words_written;

   always_ff @(posedge clock) begin
      if (commit) mem[idx] <= data_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         wcnt          <= '0;
         addr_q        <= '0;
         we_q          <= 1'b1;
         oe_q          <= 1'b1;
         data_q        <= '0;
         rd_reg        <= '0;
         err_q         <= 1'b0;
         lock_q        <= 1'b0;
         ready         <= 1'b0;
         error         <= 1'b0;
         words_written <= '0;
      end else begin
         lock_q <= lock_q | bus.Lock;
         ready  <= 1'b0;
         error  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!bus.CS) begin
                  addr_q <= bus.Address;
                  we_q   <= bus.WE;
                  oe_q   <= bus.OE;
                  data_q <= Data;
                  wcnt   <= '0;
                  state  <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.CS) begin
                  state <= S_IDLE;
               end else if (wcnt == 4'(WAIT_STATES - 1)) begin
                  state <= S_ACCESS;
               end else begin
                  wcnt <= wcnt + 4'd1;
               end
            end
            S_ACCESS: begin
               if (bus.CS) begin
                  state <= S_IDLE;
               end else begin
                  err_q <= req_err;
                  if (is_read) rd_reg <= req_err ? '0 : mem[idx];
                  if (commit && (words_written != WW_MAX))
                     words_written <= words_written + 1'b1;
                  state <= S_ACK;
               end
            end
            S_ACK: begin
               ready <= 1'b1;
               error <= err_q;
               state <= S_HOLD;
            end
            S_HOLD: begin
               if (bus.CS) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_mem_responder.sv
// Scoreboard bench: two responders (0 and 2 wait states) see identical bus traffic and are
// checked against a word-level reference model.
module tb_boot_mem_responder;

   localparam int D     = 10;
   localparam int WORDS = 1 << D;
   localparam int ROM   = 256;

   typedef struct {
      logic        err;
      logic        rd;
      logic        known;
      logic [31:0] data;
      logic [10:0] ww;
      int          cap;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] addr;
   logic        cs, we, oe, lock;
   logic [31:0] wdata;
   logic        tb_drv;
   wire  [31:0] data0, data1;

   int checks = 0, failures = 0, cyc = 0;
   int sent[2], got[2], wwm[2];
   bit lk;
   logic [31:0] mm [int];
   exp_t q0[$], q1[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   assign data0 = tb_drv ? wdata : 'z;
   assign data1 = tb_drv ? wdata : 'z;

   boot_mem_responder_if #(.DEPTH_LOG2(D)) bus0 ();
   boot_mem_responder_if #(.DEPTH_LOG2(D)) bus1 ();

   assign bus0.Address = addr;  assign bus1.Address = addr;
   assign bus0.CS = cs;         assign bus1.CS = cs;
   assign bus0.WE = we;         assign bus1.WE = we;
   assign bus0.OE = oe;         assign bus1.OE = oe;
   assign bus0.Lock = lock;     assign bus1.Lock = lock;

   boot_mem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(D), .WAIT_STATES(0), .ROM_WORDS(ROM)) u0 (
      .clock(clock), .reset_n(reset_n), .bus(bus0.slave), .Data(data0));
   boot_mem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(D), .WAIT_STATES(2), .ROM_WORDS(ROM)) u1 (
      .clock(clock), .reset_n(reset_n), .bus(bus1.slave), .Data(data1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference model: plain word memory, saturating write count, sticky lock.
   task automatic model(input int inst, input logic [31:0] a, input logic w, input logic o,
                        input logic [31:0] d, output exp_t e);
      int key;
      logic err;
      key = inst * 4096 + int'(a[11:0]);
      err = (!w && !o) || (a >= 32'(WORDS)) || (!w && o && lk && (a < 32'(ROM)));
      e.err = err; e.rd = !o && w; e.known = 1'b1; e.data = '0; e.cap = cyc + 1;
      if (!w && o && !err) begin
         mm[key] = d;
         if (wwm[inst] < WORDS) wwm[inst]++;
      end
      if (e.rd && !err) begin
         if (mm.exists(key)) e.data = mm[key];
         else e.known = 1'b0;
      end
      e.ww = 11'(wwm[inst]);
   endtask

   task automatic judge(input int inst, input exp_t e, input logic err, input logic [10:0] ww,
                        input logic drv, input logic [31:0] dat);
      string p;
      p = (inst == 0) ? "ws0" : "ws2";
      chk({p, "_latency"}, 32'(cyc - e.cap), (inst == 0) ? 32'd2 : 32'd4);
      chk({p, "_error"}, 32'(err), 32'(e.err));
      chk({p, "_words_written"}, 32'(ww), 32'(e.ww));
      chk({p, "_data_drive"}, 32'(drv), 32'(e.rd));
      if (e.rd && e.known) chk({p, "_read_data"}, dat, e.data);
   endtask

   initial begin : mon0
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clock);
         if (bus0.Ready) begin
            chk("ws0_ready_width", 32'(prev), 32'd0);
            if (q0.size() == 0) chk("ws0_spurious_ready", 32'(q0.size()), 32'd1);
            else begin
               e = q0.pop_front();
               judge(0, e, bus0.Error, bus0.Words_Written, u0.data_drive, data0);
               got[0]++;
            end
         end else if (bus0.Error) chk("ws0_error_without_ready", 32'(bus0.Error), 32'd0);
         prev = bus0.Ready;
      end
   end

   initial begin : mon1
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clock);
         if (bus1.Ready) begin
            chk("ws2_ready_width", 32'(prev), 32'd0);
            if (q1.size() == 0) chk("ws2_spurious_ready", 32'(q1.size()), 32'd1);
            else begin
               e = q1.pop_front();
               judge(1, e, bus1.Error, bus1.Words_Written, u1.data_drive, data1);
               got[1]++;
            end
         end else if (bus1.Error) chk("ws2_error_without_ready", 32'(bus1.Error), 32'd0);
         prev = bus1.Ready;
      end
   end

   task automatic wait_done();
      int t = 0;
      while ((got[0] < sent[0] || got[1] < sent[1]) && t < 60) begin
         @(posedge clock);
         t++;
      end
      if (t >= 60) chk("response_timeout", 32'(t), 32'd0);
   endtask

   task automatic access(input logic [31:0] a, input logic w, input logic o, input logic [31:0] d);
      exp_t e;
      @(negedge clock);
      model(0, a, w, o, d, e); q0.push_back(e); sent[0]++;
      model(1, a, w, o, d, e); q1.push_back(e); sent[1]++;
      addr = a; we = w; oe = o; wdata = d; tb_drv = !w; cs = 1'b0;
      @(posedge clock);
      #1;
      // Post-capture changes to address and write data must be ignored.
      addr = $urandom;
      wdata = $urandom;
      wait_done();
      @(negedge clock);
      cs = 1'b1; we = 1'b1; oe = 1'b1; tb_drv = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic rand_access();
      logic [31:0] a;
      int r;
      a = ($urandom_range(0, 15) == 0) ? (32'h0001_0000 + 32'($urandom_range(0, 4095)))
                                       : 32'($urandom_range(0, 399));
      r = $urandom_range(0, 9);
      if (r < 4)       access(a, 1'b1, 1'b0, '0);
      else if (r < 8)  access(a, 1'b0, 1'b1, $urandom);
      else if (r == 8) access(a, 1'b0, 1'b0, $urandom);
      else             access(a, 1'b1, 1'b1, '0);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_ws0_ready"}, 32'(bus0.Ready), 32'd0);
      chk({tag, "_ws2_ready"}, 32'(bus1.Ready), 32'd0);
      chk({tag, "_ws0_error"}, 32'(bus0.Error), 32'd0);
      chk({tag, "_ws2_error"}, 32'(bus1.Error), 32'd0);
      chk({tag, "_ws0_words"}, 32'(bus0.Words_Written), 32'd0);
      chk({tag, "_ws2_words"}, 32'(bus1.Words_Written), 32'd0);
      chk({tag, "_ws0_drive"}, 32'(u0.data_drive), 32'd0);
      chk({tag, "_ws2_drive"}, 32'(u1.data_drive), 32'd0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      exp_t e;
      sent = '{0, 0}; got = '{0, 0}; wwm = '{0, 0}; lk = 1'b0;
      reset_n = 1'b0; cs = 1'b1; we = 1'b1; oe = 1'b1; lock = 1'b0;
      addr = '0; wdata = '0; tb_drv = 1'b0;
      repeat (3) @(negedge clock);
      reset_checks("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      access(32'd5, 1'b0, 1'b1, 32'h0000_0033);
      access(32'd5, 1'b1, 1'b0, '0);
      access(32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      access(32'd0, 1'b1, 1'b0, '0);
      access(32'd5, 1'b0, 1'b0, 32'hFFFF_FFFF);
      access(32'd5, 1'b1, 1'b0, '0);
      access(32'd5, 1'b1, 1'b1, '0);
      access(32'd10, 1'b0, 1'b1, 32'h0000_1010);
      access(32'd20, 1'b0, 1'b1, 32'h0000_0020);
      access(32'd21, 1'b0, 1'b1, 32'h0000_0021);

      // CS rises in the wait phase of the 2-wait responder; the 0-wait one has already committed.
      @(negedge clock);
      model(0, 32'd20, 1'b0, 1'b1, 32'hAAAA_0001, e); q0.push_back(e); sent[0]++;
      addr = 32'd20; we = 1'b0; oe = 1'b1; wdata = 32'hAAAA_0001; tb_drv = 1'b1; cs = 1'b0;
      @(posedge clock); @(posedge clock);
      @(negedge clock);
      cs = 1'b1; we = 1'b1; tb_drv = 1'b0;
      wait_done();
      repeat (4) @(negedge clock);

      // Reset asserted during the wait phase; only the 0-wait responder has written memory.
      @(negedge clock);
      model(0, 32'd21, 1'b0, 1'b1, 32'hBBBB_0002, e);
      addr = 32'd21; we = 1'b0; oe = 1'b1; wdata = 32'hBBBB_0002; tb_drv = 1'b1; cs = 1'b0;
      @(posedge clock); @(posedge clock);
      #2 reset_n = 1'b0;
      @(negedge clock);
      cs = 1'b1; we = 1'b1; tb_drv = 1'b0;
      repeat (2) @(negedge clock);
      reset_checks("abort_reset");
      wwm = '{0, 0}; lk = 1'b0;
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      access(32'd20, 1'b1, 1'b0, '0);
      access(32'd21, 1'b1, 1'b0, '0);

      repeat (40) rand_access();

      @(negedge clock);
      lock = 1'b1; lk = 1'b1;
      repeat (2) @(negedge clock);
      access(32'd10, 1'b0, 1'b1, 32'h0000_0001);
      access(32'd10, 1'b1, 1'b0, '0);
      access(32'd300, 1'b0, 1'b1, 32'h0000_0002);
      access(32'd300, 1'b1, 1'b0, '0);
      access(32'h0001_0000, 1'b1, 1'b0, '0);
      access(32'h0001_0000, 1'b0, 1'b1, 32'h1234_5678);

      repeat (40) rand_access();

      repeat (4) @(negedge clock);
      chk("ws0_pending_responses", 32'(q0.size()), 32'd0);
      chk("ws2_pending_responses", 32'(q1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
